// File: rtl/dma_w_burst_ctrl_pkg.sv
// Shared types and helpers for the write-side burst scheduler and its length calculator.
package dma_w_burst_ctrl_pkg;

    localparam int unsigned DEF_BOUNDARY = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_WAIT_RESP,
        ST_FINISH
    } state_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational burst length: min of remaining beats, programmed cap and beats left before the boundary.
module dma_burst_calc
    import dma_w_burst_ctrl_pkg::*;
#(
    parameter int unsigned DMA_DATA_W = 32,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned XFER_W     = 24,
    parameter int unsigned BOUNDARY   = DEF_BOUNDARY
) (
    input  logic [$clog2(BOUNDARY)-1:0] i_addr_ofs,
    input  logic [XFER_W-1:0]           i_words_left,
    input  logic [LEN_W-1:0]            i_max_len,
    output logic [LEN_W:0]              o_beats
);

    localparam int unsigned BPW    = DMA_DATA_W / 8;
    localparam int unsigned BPW_SH = $clog2(BPW);
    localparam int unsigned OFS_W  = $clog2(BOUNDARY);
    localparam int unsigned CW     = max2(max2(XFER_W, OFS_W + 1), LEN_W + 1);

    logic [OFS_W:0] w_bnd_bytes;
    logic [CW-1:0]  w_bnd_beats;
    logic [CW-1:0]  w_cap;
    logic [CW-1:0]  w_words;
    logic [CW-1:0]  w_min_a;
    logic [CW-1:0]  w_min_b;

    // An offset of zero yields the full window of BOUNDARY bytes.
    assign w_bnd_bytes = (OFS_W + 1)'(BOUNDARY) - {1'b0, i_addr_ofs};
    assign w_bnd_beats = CW'(w_bnd_bytes) >> BPW_SH;
    assign w_cap       = CW'(i_max_len) + CW'(1);
    assign w_words     = CW'(i_words_left);

    assign w_min_a = (w_words < w_cap) ? w_words : w_cap;
    assign w_min_b = (w_min_a < w_bnd_beats) ? w_min_a : w_bnd_beats;
    assign o_beats = (LEN_W + 1)'(w_min_b);

endmodule

// File: rtl/dma_w_burst_ctrl.sv
// Write DMA burst scheduler: splits a transfer into boundary-safe INCR bursts and tracks completion.
module dma_w_burst_ctrl
    import dma_w_burst_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DMA_DATA_W = 32,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned XFER_W     = 24,
    parameter int unsigned BOUNDARY   = DEF_BOUNDARY
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_start,
    input  logic [ADDR_W-1:0] i_cfg_addr,
    input  logic [XFER_W-1:0] i_cfg_words,
    input  logic [LEN_W-1:0]  i_cfg_max_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [XFER_W-1:0] o_words_left,
    output logic              o_eng_valid,
    output logic [ADDR_W-1:0] o_eng_addr,
    output logic [LEN_W-1:0]  o_eng_len,
    input  logic              i_eng_ready,
    input  logic              i_eng_dma_ready,
    input  logic              i_eng_error
);

    localparam int unsigned BPW    = DMA_DATA_W / 8;
    localparam int unsigned BPW_SH = $clog2(BPW);
    localparam int unsigned OFS_W  = $clog2(BOUNDARY);

    state_e            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [XFER_W-1:0] r_words_left;
    logic              r_eng_valid;
    logic [ADDR_W-1:0] r_eng_addr;
    logic [LEN_W-1:0]  r_eng_len;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_max_len;
    logic [LEN_W:0]    r_beat_cnt;
    logic [LEN_W:0]    w_beats;

    dma_burst_calc #(
        .DMA_DATA_W (DMA_DATA_W),
        .LEN_W      (LEN_W),
        .XFER_W     (XFER_W),
        .BOUNDARY   (BOUNDARY)
    ) u_calc (
        .i_addr_ofs   (r_addr[OFS_W-1:0]),
        .i_words_left (r_words_left),
        .i_max_len    (r_max_len),
        .o_beats      (w_beats)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_words_left <= '0;
            r_eng_valid  <= 1'b0;
            r_eng_addr   <= '0;
            r_eng_len    <= '0;
            r_addr       <= '0;
            r_max_len    <= '0;
            r_beat_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cfg_start) begin
                        r_addr       <= i_cfg_addr;
                        r_words_left <= i_cfg_words;
                        r_max_len    <= i_cfg_max_len;
                        r_error      <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= (i_cfg_words == '0) ? ST_FINISH : ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_eng_addr <= r_addr;
                    r_eng_len  <= LEN_W'(w_beats - (LEN_W + 1)'(1));
                    r_beat_cnt <= w_beats;
                    if (i_eng_dma_ready) begin
                        r_eng_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i_eng_ready) begin
                        r_words_left <= r_words_left - XFER_W'(1);
                        r_beat_cnt   <= r_beat_cnt - (LEN_W + 1)'(1);
                        // Last beat of the burst: release the request and move past it.
                        if (r_beat_cnt == (LEN_W + 1)'(1)) begin
                            r_eng_valid <= 1'b0;
                            r_addr      <= r_eng_addr
                                         + ((ADDR_W'(r_eng_len) + ADDR_W'(1)) << BPW_SH);
                            r_state     <= ST_WAIT_RESP;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (i_eng_dma_ready) begin
                        if (i_eng_error) begin
                            r_error <= 1'b1;
                            r_state <= ST_FINISH;
                        end else if (r_words_left == '0) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_words_left = r_words_left;
    assign o_eng_valid  = r_eng_valid;
    assign o_eng_addr   = r_eng_addr;
    assign o_eng_len    = r_eng_len;

endmodule

// File: tb/tb_dma_w_burst_ctrl.sv
// Scoreboard bench for dma_w_burst_ctrl: random transfers against a burst-splitting reference model.
module tb_dma_w_burst_ctrl;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned XFER_W   = 24;
    localparam int unsigned BOUNDARY = 4096;
    localparam int unsigned BPW      = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_start = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [XFER_W-1:0] cfg_words = '0;
    logic [LEN_W-1:0]  cfg_max_len = '0;
    logic              o_busy, o_done, o_error, o_eng_valid;
    logic [XFER_W-1:0] o_words_left;
    logic [ADDR_W-1:0] o_eng_addr;
    logic [LEN_W-1:0]  o_eng_len;
    logic              eng_ready = 1'b0;
    logic              eng_dma_ready = 1'b1;
    logic              eng_error = 1'b0;

    dma_w_burst_ctrl #(
        .ADDR_W(ADDR_W), .DMA_DATA_W(DATA_W), .LEN_W(LEN_W), .XFER_W(XFER_W), .BOUNDARY(BOUNDARY)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_start(cfg_start), .i_cfg_addr(cfg_addr),
        .i_cfg_words(cfg_words), .i_cfg_max_len(cfg_max_len), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_words_left(o_words_left), .o_eng_valid(o_eng_valid),
        .o_eng_addr(o_eng_addr), .o_eng_len(o_eng_len), .i_eng_ready(eng_ready),
        .i_eng_dma_ready(eng_dma_ready), .i_eng_error(eng_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    longint q_baddr[$];
    longint q_blen[$];
    longint q_derr[$];
    longint q_dwl[$];

    int inj_err_at = -1;
    int burst_no   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: condition not met at %0t", nm, $time);
    endtask

    // Reference: greedy split honoring remaining beats, length cap and 4 KB windows.
    task automatic model(input longint addr, input longint words, input int ml, input int err_at);
        longint a   = addr;
        longint rem = words;
        int     idx = 0;
        bit     e   = 1'b0;
        while (rem > 0 && !e) begin
            longint b   = rem;
            longint cap = longint'(ml) + 1;
            longint bnd = (longint'(BOUNDARY) - (a % longint'(BOUNDARY))) / longint'(BPW);
            if (cap < b) b = cap;
            if (bnd < b) b = bnd;
            q_baddr.push_back(a);
            q_blen.push_back(b - 1);
            rem = rem - b;
            a   = (a + b * longint'(BPW)) % 64'h1_0000_0000;
            if (idx == err_at) e = 1'b1;
            idx++;
        end
        q_derr.push_back(longint'(e));
        q_dwl.push_back(rem);
    endtask

    // Engine model: accepts beats with random stalls, responds after a random delay.
    int                e_st = 0;
    int                e_left = 0;
    int                e_dly = 0;
    int                e_idx = 0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [LEN_W-1:0]  e_len = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                e_st = 0; eng_ready = 1'b0; eng_dma_ready = 1'b1; eng_error = 1'b0;
            end else begin
                case (e_st)
                    0: if (o_eng_valid) begin
                        e_addr = o_eng_addr;
                        e_len  = o_eng_len;
                        e_left = int'(e_len) + 1;
                        e_idx  = burst_no;
                        burst_no++;
                        eng_dma_ready = 1'b0;
                        eng_error     = 1'b0;
                        eng_ready     = ($urandom_range(0, 2) != 0);
                        e_st = 1;
                    end
                    1: begin
                        if (eng_ready) e_left--;
                        if (e_left == 0) begin
                            eng_ready = 1'b0;
                            chk("valid_drop_after_last", longint'(o_eng_valid), 0);
                            e_dly = $urandom_range(0, 3);
                            e_st  = 2;
                        end else begin
                            chk("valid_held", longint'(o_eng_valid), 1);
                            chk("addr_stable", longint'(o_eng_addr), longint'(e_addr));
                            chk("len_stable", longint'(o_eng_len), longint'(e_len));
                            eng_ready = ($urandom_range(0, 2) != 0);
                        end
                    end
                    default: begin
                        if (e_dly == 0) begin
                            eng_dma_ready = 1'b1;
                            eng_error     = (e_idx == inj_err_at);
                            e_st = 0;
                        end else begin
                            e_dly--;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: checks each new burst request and each completion against the queues.
    initial begin
        logic pv = 1'b0;
        logic pd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pv = 1'b0; pd = 1'b0;
            end else begin
                if (o_eng_valid && !pv) begin
                    if (q_baddr.size() == 0) begin
                        flag("unexpected_burst");
                    end else begin
                        chk("burst_addr", longint'(o_eng_addr), q_baddr.pop_front());
                        chk("burst_len", longint'(o_eng_len), q_blen.pop_front());
                    end
                end
                if (o_done) begin
                    chk("done_one_cycle", longint'(pd), 0);
                    if (q_derr.size() == 0) begin
                        flag("unexpected_done");
                    end else begin
                        chk("done_error", longint'(o_error), q_derr.pop_front());
                        chk("done_words_left", longint'(o_words_left), q_dwl.pop_front());
                    end
                    chk("busy_falls_with_done", longint'(o_busy), 0);
                    chk("bursts_pending_at_done", longint'(q_baddr.size()), 0);
                end
                pv = o_eng_valid;
                pd = o_done;
            end
        end
    end

    task automatic start_xfer(input longint addr, input longint words, input int ml, input int err_at);
        model(addr, words, ml, err_at);
        @(negedge clk);
        inj_err_at  = err_at;
        burst_no    = 0;
        cfg_addr    = ADDR_W'(addr);
        cfg_words   = XFER_W'(words);
        cfg_max_len = LEN_W'(ml);
        cfg_start   = 1'b1;
        @(negedge clk);
        cfg_start   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (o_done) return;
        end
        flag("done_timeout");
    endtask

    initial begin
        #2;
        chk("rst_busy", longint'(o_busy), 0);
        chk("rst_done", longint'(o_done), 0);
        chk("rst_error", longint'(o_error), 0);
        chk("rst_words_left", longint'(o_words_left), 0);
        chk("rst_eng_valid", longint'(o_eng_valid), 0);
        chk("rst_eng_addr", longint'(o_eng_addr), 0);
        chk("rst_eng_len", longint'(o_eng_len), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single burst; request rises on the second edge after start.
        start_xfer(64'h0, 16, 255, -1);
        @(posedge clk);
        #1;
        chk("valid_2nd_edge", longint'(o_eng_valid), 1);
        chk("busy_during_xfer", longint'(o_busy), 1);
        wait_done(2000);

        // Split at the 4 KB boundary.
        start_xfer(64'h0FF0, 8, 255, -1);
        wait_done(2000);

        // Three bursts, last one partial.
        start_xfer(64'h0, 600, 255, -1);
        wait_done(5000);
        chk("words_left_end", longint'(o_words_left), 0);

        // Error on the first burst aborts the rest; error is sticky until the next start.
        start_xfer(64'h0, 600, 255, 0);
        wait_done(5000);
        @(negedge clk);
        chk("error_sticky", longint'(o_error), 1);
        chk("words_left_after_err", longint'(o_words_left), 344);
        start_xfer(64'h3000, 5, 255, -1);
        chk("error_cleared_by_start", longint'(o_error), 0);
        wait_done(2000);

        // Zero-length transfer.
        start_xfer(64'h40, 0, 255, -1);
        @(posedge clk);
        #1;
        chk("zero_done_2_cycles", longint'(o_done), 1);
        chk("zero_busy_low", longint'(o_busy), 0);

        // A start pulse during a busy transfer is ignored.
        start_xfer(64'h100, 40, 7, -1);
        repeat (5) @(negedge clk);
        cfg_addr = 32'h2000; cfg_words = 5; cfg_max_len = 0; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_done(2000);

        // Address wrap at the top of the address space, and an exact-boundary start.
        start_xfer(64'hFFFF_FFF0, 10, 255, -1);
        wait_done(2000);
        start_xfer(64'h1000, 1100, 255, -1);
        wait_done(8000);

        // Asynchronous reset in the middle of a burst.
        start_xfer(64'h0, 600, 255, -1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(posedge clk);
                #1;
                seen = o_eng_valid;
            end
            if (!seen) flag("valid_wait_timeout");
        end
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_eng_valid", longint'(o_eng_valid), 0);
        chk("midrst_busy", longint'(o_busy), 0);
        chk("midrst_words_left", longint'(o_words_left), 0);
        chk("midrst_eng_len", longint'(o_eng_len), 0);
        q_baddr.delete(); q_blen.delete(); q_derr.delete(); q_dwl.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_xfer(64'h0, 16, 255, -1);
        wait_done(2000);

        // Randomized transfers.
        for (int t = 0; t < 24; t++) begin
            longint a;
            int     pick = $urandom_range(0, 2);
            int     ml   = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 63);
            int     ea   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            int     w    = $urandom_range(0, 400);
            if (pick == 0)
                a = longint'($urandom & 32'hFFFF_FFFC);
            else if (pick == 1)
                a = longint'(($urandom & 32'hFFFF_F000) | (32'd4096 - 32'(4 * $urandom_range(1, 16))));
            else
                a = longint'($urandom & 32'hFFFF_F000);
            start_xfer(a, longint'(w), ml, ea);
            wait_done(5000);
        end

        repeat (5) @(negedge clk);
        chk("queues_drained", longint'(q_baddr.size() + q_derr.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_w_burst_ctrl.md
# dma_w_burst_ctrl

Burst scheduler for the AXI write DMA engine. Accepts one transfer command (start address plus total word count) and splits it into AXI INCR bursts. Each burst is capped by a programmable maximum length and never crosses a 4 KB boundary. For each burst it drives the engine's `valid`, `addr` and `dma_len` inputs, counts accepted beats, waits for the write response, and reports completion and sticky error to the register bank.

## Interface
Parameters:
- `ADDR_W`, `AXI_ADDR_W`: byte address width.
- `DMA_DATA_W`, 32: data width. Bytes per beat `BPW = DMA_DATA_W/8`.
- `LEN_W`, `AXI_LEN_W`: width of the burst length field (beats-1).
- `XFER_W`, 24: width of the total word count.
- `BOUNDARY`, 4096: burst boundary in bytes. Must be a power of two.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cfg_start` in 1: one-cycle start pulse.
- `cfg_addr` in `ADDR_W`: start byte address, BPW-aligned.
- `cfg_words` in `XFER_W`: total beats. 0 means no-op.
- `cfg_max_len` in `LEN_W`: maximum beats-1 per burst.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at end of transfer.
- `error` out 1: sticky error, cleared by the next accepted `cfg_start`.
- `words_left` out `XFER_W`: beats not yet accepted.
- `eng_valid` out 1: engine request. Held high for the whole burst.
- `eng_addr` out `ADDR_W`: burst start address.
- `eng_len` out `LEN_W`: burst beats-1.
- `eng_ready` in 1: engine accepted one data beat.
- `eng_dma_ready` in 1: engine idle and ready for a new burst.
- `eng_error` in 1: engine error flag, valid once `eng_dma_ready` is high.

## Operation
States: IDLE, CALC, ISSUE, WAIT_RESP, FINISH.
- **IDLE**
  - On `cfg_start`: latch `cfg_addr`/`cfg_words`/`cfg_max_len`, clear `error`, set `busy`.
  - If `cfg_words`==0, go to FINISH. Otherwise go to CALC.
  - `cfg_start` in any other state is ignored.
- **CALC**
  - `beats = min(words_left, cfg_max_len+1, (BOUNDARY - addr%BOUNDARY)/BPW)`.
  - Register `eng_len = beats-1` and `eng_addr = addr`.
  - Go to ISSUE once `eng_dma_ready`==1; otherwise stay in CALC.
- **ISSUE**
  - `eng_valid`=1.
  - Each `eng_ready` decrements `words_left` and the burst beat counter.
  - In the cycle the counter reaches 0 (last beat):
    - `eng_valid` goes low at the next edge.
    - `addr` advances by `beats*BPW`.
    - Go to WAIT_RESP.
- **WAIT_RESP**: wait for `eng_dma_ready`==1, then sample `eng_error`.
  - `eng_error`=1: set `error` and go to FINISH, aborting the remaining bursts. `words_left` keeps its value.
  - `eng_error`=0 and `words_left`==0: go to FINISH.
  - Otherwise go to CALC.
- **FINISH**: pulse `done` for one cycle, clear `busy`, return to IDLE.

Arithmetic and boundary rules:
- Compute `beats` at `LEN_W+1` bits, so `cfg_max_len` all-ones gives 2^`LEN_W` beats with no wrap.
- An address exactly on a boundary allows a full `BOUNDARY/BPW` beats.
- Address arithmetic wraps modulo 2^`ADDR_W`.

## Timing
- Reset values: `busy`=0, `done`=0, `error`=0, `words_left`=0, `eng_valid`=0, `eng_addr`=0, `eng_len`=0, state IDLE.
- With the engine idle, `eng_valid` rises on the 2nd edge after the `cfg_start` cycle (IDLE→CALC→ISSUE).
- `eng_valid` is low for at least one cycle between bursts.
- `eng_addr` and `eng_len` are stable for the whole time `eng_valid` is high.
- Burst-to-burst overhead, excluding engine response latency: WAIT_RESP→CALC→ISSUE = 2 cycles.
- `done` is asserted the cycle after the final WAIT_RESP exit. `busy` falls together with `done`.
- `rst` mid-transfer forces all outputs to their reset values immediately (asynchronous).

## Structure
- Shared header `dma_ctrl.vh`:
  - state encodings (`DMA_CTRL_STATES_W`, state defines);
  - `BOUNDARY` default.
- Sub-module `dma_burst_calc`, purely combinational:
  - inputs `addr`, `words_left`, `max_len`;
  - output `beats`;
  - reusable by the read-side controller.
- The FSM, latches and counters live in `dma_w_burst_ctrl`.

## Test plan
- `cfg_addr`=0x0, `cfg_words`=16, `cfg_max_len`=255, `BPW`=4 → one burst: `eng_len`=15, `eng_addr`=0x0, 16 `eng_ready` beats, then one `done` pulse, `error`=0.
- `cfg_addr`=0x0FF0, `cfg_words`=8 → burst 1 at 0x0FF0 with `eng_len`=3; burst 2 at 0x1000 with `eng_len`=3. No burst crosses 0x1000.
- `cfg_words`=600, `cfg_max_len`=255, `cfg_addr`=0x0 → three bursts:
  - `eng_len`=255 at 0x000;
  - `eng_len`=255 at 0x400;
  - `eng_len`=87 at 0x800.
  - `words_left` ends at 0.
- `eng_error`=1 on the first of three bursts → no second `eng_valid`; `error`=1, `done` pulses, `words_left` equals the remaining beats. The next `cfg_start` clears `error`.
- `cfg_words`=0 → `done` pulses 2 cycles after start, `eng_valid` never rises. A `cfg_start` during a busy transfer has no effect.
- `rst` asserted mid-ISSUE → `eng_valid`/`busy` go to 0 immediately, and a new start after reset runs normally.
